// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the 4-requester round-robin mux arbiter.
// Optional grant counters are enabled with MUX_ARB_GRANT_CNT_EN.
package mux_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    function automatic logic [SEL_W-1:0] onehot_to_idx(
        input logic [NUM_REQ-1:0] oh
    );
        logic [SEL_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (oh[i]) idx = i[SEL_W-1:0];
        end
        return idx;
    endfunction

endpackage

// File: rtl/mux_rr_pick.sv
// Combinational round-robin pick: first requester after 'last', wrapping,
// optionally skipping one index.
module mux_rr_pick
    import mux_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   last,
    input  logic               exclude_en,
    input  logic [SEL_W-1:0]   exclude_idx,
    output logic               any,
    output logic [SEL_W-1:0]   idx
);

    logic [NUM_REQ-1:0] masked;
    logic [SEL_W-1:0]   cand;

    always_comb begin
        masked = req;
        any    = 1'b0;
        idx    = '0;
        cand   = '0;
        if (exclude_en) masked[exclude_idx] = 1'b0;
        // Offset NUM_REQ wraps back onto 'last' itself, which is checked last.
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = last + k[SEL_W-1:0];
            if (!any && masked[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving the 4:1 mux selects with bounded bursts.
// Define MUX_ARB_GRANT_CNT_EN to add per-requester saturating grant counters.
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int DATA_W    = 1,
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] w,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      S1,
    output logic                      S0,
    output logic [DATA_W-1:0]         y,
    output logic                      y_valid
`ifdef MUX_ARB_GRANT_CNT_EN
    ,
    output logic [NUM_REQ*8-1:0]      grant_cnt
`endif
);

    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] BURST_ONE = CNT_W'(1);

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [SEL_W-1:0]   last_q, last_d;
    logic [CNT_W-1:0]   burst_q, burst_d;
    logic               grant_evt;

    logic [SEL_W-1:0]   cur;
    logic               pick_any;
    logic [SEL_W-1:0]   pick_idx;
    logic               expired;

    assign cur     = onehot_to_idx(gnt_q);
    assign expired = (state_q == ST_GRANT) && req[cur] && (burst_q == BURST_MAX);

    mux_rr_pick u_pick (
        .req         (req),
        .last        (last_q),
        .exclude_en  (expired),
        .exclude_idx (cur),
        .any         (pick_any),
        .idx         (pick_idx)
    );

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        sel_d     = sel_q;
        last_d    = last_q;
        burst_d   = burst_q;
        grant_evt = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d   = ST_GRANT;
                    gnt_d     = NUM_REQ'(1) << pick_idx;
                    sel_d     = pick_idx;
                    last_d    = pick_idx;
                    burst_d   = BURST_ONE;
                    grant_evt = 1'b1;
                end
            end
            ST_GRANT: begin
                if (!req[cur] || expired) begin
                    if (pick_any) begin
                        gnt_d     = NUM_REQ'(1) << pick_idx;
                        sel_d     = pick_idx;
                        last_d    = pick_idx;
                        burst_d   = BURST_ONE;
                        grant_evt = 1'b1;
                    end else if (!req[cur]) begin
                        // Select deliberately holds its last value while idle.
                        state_d = ST_IDLE;
                        gnt_d   = '0;
                        burst_d = '0;
                    end else begin
                        last_d    = cur;
                        burst_d   = BURST_ONE;
                        grant_evt = 1'b1;
                    end
                end else begin
                    burst_d = burst_q + BURST_ONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            last_q  <= SEL_W'(NUM_REQ - 1);
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            burst_q <= burst_d;
        end
    end

    assign gnt     = gnt_q;
    assign S1      = sel_q[1];
    assign S0      = sel_q[0];
    assign y_valid = |gnt_q;
    assign y       = y_valid ? w[sel_q*DATA_W +: DATA_W] : '0;

`ifdef MUX_ARB_GRANT_CNT_EN
    logic [7:0] cnt_q [NUM_REQ];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
        end else if (grant_evt && cnt_q[last_d] != 8'hff) begin
            cnt_q[last_d] <= cnt_q[last_d] + 8'd1;
        end
    end

    always_comb begin
        grant_cnt = '0;
        for (int i = 0; i < NUM_REQ; i++) grant_cnt[i*8 +: 8] = cnt_q[i];
    end
`endif

endmodule
